alu_acc: RTL and testbench
==========================

ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal values 4..32.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 enable  input  1  high = block advances; low = full stall.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 opcode  input  4  operation select.
REQ-009 in_sel  input  1  unary-operand select: 1 = in_a, 0 = in_b.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out  output  WIDTH  result, low half for MUL.
REQ-013 out_hi  output  WIDTH  MUL high half; 0 for all other ops.
REQ-014 flag_c, flag_z, flag_n, flag_v  output  1 each  carry/borrow, zero, negative, signed overflow.

Function
REQ-015 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT s; 6 INC s; 7 DEC s; 8 SHL s by 1; 9 SHR s by 1 (logical); 10 ROL s; 11 ROR s; 12 CMP (flags of a-b, out=0); 13 MUL unsigned a*b, 2*WIDTH product {out_hi,out}; 14 ACC acc=acc+s, out=new acc; 15 CLRACC acc=0, out=0. s = in_sel ? in_a : in_b.
REQ-016 FSM states IDLE, EXEC, MUL, DONE; reset state IDLE.
REQ-017 in_ready = 1 only in IDLE with enable=1; accept occurs on in_valid && in_ready at a clk edge; operands and opcode captured on accept.
REQ-018 IDLE -> EXEC on accept of opcode != 13; IDLE -> MUL on accept of opcode 13.
REQ-019 EXEC -> DONE after one cycle; out_valid asserts 2 cycles after the accept edge.
REQ-020 MUL iterates one shift-add step per enabled cycle for WIDTH cycles then -> DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-021 DONE -> IDLE on out_valid && out_ready at clk edge; no new accept in that same cycle.
REQ-022 out, out_hi, flags registered; stable while out_valid=1 and out_ready=0.
REQ-023 flag_c: ADD/INC carry out; SUB/DEC/CMP borrow (1 when minuend < subtrahend unsigned); SHL/ROL = old MSB; SHR/ROR = old LSB; ACC carry out; else 0.
REQ-024 flag_v: signed overflow for ADD/SUB/INC/DEC/CMP/ACC; else 0.
REQ-025 flag_z: result == 0 (MUL: full 2*WIDTH product == 0; CMP: a == b).
REQ-026 flag_n: MSB of out (MUL: MSB of out_hi; CMP: MSB of a-b).
REQ-027 All arithmetic modulo 2^WIDTH except MUL; INC of all-ones wraps to 0 with flag_c=1.
REQ-028 Accumulator acc (WIDTH) persists across operations; modified only by ACC, CLRACC and reset.
REQ-029 enable=0: no state, counter, acc or output register changes; in_ready=0; out_valid holds its value; handshake on out side ignored.

Reset
REQ-030 reset=0 at clk edge: state IDLE, acc=0, out=0, out_hi=0, all flags 0, out_valid=0, MUL counter 0; in_ready=0 while reset=0.
REQ-031 Reset mid-EXEC, MUL or DONE aborts the operation; no result emitted afterwards.

Structure
REQ-032 Shared package alu_pkg holds opcode enumeration, FSM state enumeration and opcode width constant.
REQ-033 Sequential multiplier is sub-module alu_mul_seq (start, enable, operands, done, 2*WIDTH product).

Verification
REQ-034 WIDTH=8, a=11, b=2, ADD -> out=13, flags 0, out_valid 2 cycles after accept.
REQ-035 SUB a=2, b=11 -> out=0xF7, flag_c=1, flag_n=1, flag_z=0, flag_v=0; CMP a=5, b=5 -> out=0, flag_z=1.
REQ-036 MUL a=200, b=3 -> out_hi=0x02, out=0x58, out_valid 9 cycles after accept; a=0 -> flag_z=1.
REQ-037 ACC in_sel=1, a=0x80 twice -> out 0x80 then 0x00 with flag_c=1, flag_v=1; hold out_ready=0 5 cycles -> out stable, in_ready=0.
REQ-038 enable=0 for 3 cycles mid-MUL -> out_valid delayed exactly 3 cycles, product unchanged.
REQ-039 reset=0 during MUL cycle 4 -> next cycle all outputs 0, state IDLE, acc=0; following ADD 1+1 -> out=2.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state enumerations and overflow helpers for alu_acc
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_NOT    = 4'd5,
        OP_INC    = 4'd6,
        OP_DEC    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_ROL    = 4'd10,
        OP_ROR    = 4'd11,
        OP_CMP    = 4'd12,
        OP_MUL    = 4'd13,
        OP_ACC    = 4'd14,
        OP_CLRACC = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

    // Signed overflow from operand and result sign bits.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_acc_if.sv
// rtl/alu_acc_if.sv - operation request / result handshake bundle for alu_acc
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [OPCODE_W-1:0] opcode;
    logic                in_sel;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out;
    logic [WIDTH-1:0]    out_hi;
    logic                flag_c;
    logic                flag_z;
    logic                flag_n;
    logic                flag_v;

    modport master (
        output in_valid, in_a, in_b, opcode, in_sel, out_ready,
        input  in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_n, flag_v
    );

    modport slave (
        input  in_valid, in_a, in_b, opcode, in_sel, out_ready,
        output in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_n, flag_v
    );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - WIDTH-step shift-add unsigned multiplier
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   a_q;
    logic [CW-1:0]      cnt_q;

    // Multiplier bits sit in the low half and are consumed LSB first.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] upper;
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {upper, p[WIDTH-1:1]};
    endfunction

    assign done    = (cnt_q == CW'(WIDTH));
    assign product = prod_q;

    // The start cycle already performs the first step, so done rises WIDTH-1 edges later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q <= '0;
            a_q    <= '0;
            cnt_q  <= '0;
        end else if (enable) begin
            if (start) begin
                prod_q <= mul_step({{WIDTH{1'b0}}, b}, a);
                a_q    <= a;
                cnt_q  <= CW'(1);
            end else if (cnt_q != '0 && !done) begin
                prod_q <= mul_step(prod_q, a_q);
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_acc.sv
// rtl/alu_acc.sv - handshaked ALU with accumulator and sequential multiplier
module alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    alu_acc_if.slave   bus
);
    localparam int M = WIDTH - 1;

    state_e             state_q, state_d;
    opcode_e            op_q;
    logic [WIDTH-1:0]   a_q, b_q, acc_q;
    logic               sel_q;
    logic               accept, capture, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   out_q, out_hi_q;
    logic               c_q, z_q, n_q, v_q, out_valid_q;

    logic [WIDTH-1:0]   s, res, res_hi;
    logic [WIDTH:0]     sum_ab, diff_ab, inc_s, dec_s, acc_sum;
    logic               res_c, res_z, res_n, res_v;

    always_comb begin
        state_d   = state_q;
        bus.in_ready = (state_q == S_IDLE) && enable && reset;
        accept    = bus.in_valid && bus.in_ready;
        mul_start = accept && (opcode_e'(bus.opcode) == OP_MUL);
        capture   = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = mul_start ? S_MUL : S_EXEC;
            S_EXEC: begin
                capture = enable;
                state_d = S_DONE;
            end
            S_MUL: if (mul_done) begin
                capture = enable;
                state_d = S_DONE;
            end
            S_DONE: if (out_valid_q && bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else if (enable) state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= 1'b0;
        end else if (accept) begin
            op_q  <= opcode_e'(bus.opcode);
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            sel_q <= bus.in_sel;
        end
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (mul_start),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        s       = sel_q ? a_q : b_q;
        sum_ab  = {1'b0, a_q} + {1'b0, b_q};
        diff_ab = {1'b0, a_q} - {1'b0, b_q};
        inc_s   = {1'b0, s} + (WIDTH+1)'(1);
        dec_s   = {1'b0, s} - (WIDTH+1)'(1);
        acc_sum = {1'b0, acc_q} + {1'b0, s};
        res     = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (op_q)
            OP_ADD: begin res = sum_ab[M:0]; res_c = sum_ab[WIDTH]; res_v = add_ovf(a_q[M], b_q[M], res[M]); end
            OP_SUB, OP_CMP: begin
                res   = diff_ab[M:0];
                res_c = diff_ab[WIDTH];
                res_v = sub_ovf(a_q[M], b_q[M], res[M]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOT: res = ~s;
            OP_INC: begin res = inc_s[M:0]; res_c = inc_s[WIDTH]; res_v = add_ovf(s[M], 1'b0, res[M]); end
            OP_DEC: begin res = dec_s[M:0]; res_c = dec_s[WIDTH]; res_v = sub_ovf(s[M], 1'b0, res[M]); end
            OP_SHL: begin res = {s[M-1:0], 1'b0}; res_c = s[M]; end
            OP_SHR: begin res = {1'b0, s[M:1]};   res_c = s[0]; end
            OP_ROL: begin res = {s[M-1:0], s[M]}; res_c = s[M]; end
            OP_ROR: begin res = {s[0], s[M:1]};   res_c = s[0]; end
            OP_MUL: begin res = mul_product[M:0]; res_hi = mul_product[2*WIDTH-1:WIDTH]; end
            OP_ACC: begin res = acc_sum[M:0]; res_c = acc_sum[WIDTH]; res_v = add_ovf(acc_q[M], s[M], res[M]); end
            OP_CLRACC: res = '0;
            default: res = '0;
        endcase
        // CMP reports the subtraction flags but presents a zero result.
        res_z = (res == '0) && (res_hi == '0);
        res_n = (op_q == OP_MUL) ? res_hi[M] : res[M];
        if (op_q == OP_CMP) res = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q       <= '0;
            out_hi_q    <= '0;
            {c_q, z_q, n_q, v_q} <= 4'b0000;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else if (enable) begin
            if (capture) begin
                out_q    <= res;
                out_hi_q <= res_hi;
                {c_q, z_q, n_q, v_q} <= {res_c, res_z, res_n, res_v};
                if (op_q == OP_ACC)    acc_q <= res;
                if (op_q == OP_CLRACC) acc_q <= '0;
            end
            if (state_q == S_DONE) begin
                if (!out_valid_q)       out_valid_q <= 1'b1;
                else if (bus.out_ready) out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_hi    = out_hi_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_v    = v_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_acc.sv
// tb/tb_alu_acc.sv - directed self-checking bench for alu_acc (WIDTH=8)
module tb_alu_acc;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    logic seen_valid;

    alu_acc_if #(.WIDTH(8)) bus ();

    alu_acc #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sel);
        @(negedge clk);
        bus.opcode   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        bus.in_valid = 1'b1;
        #1 chk("in_ready_before_accept", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic expect_res(input string tag, input int got_lat, input int exp_lat,
                              input logic [7:0] e_out, input logic [7:0] e_hi,
                              input logic [3:0] e_czvn);
        chk({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
        chk({tag, "_out"}, 32'(bus.out), 32'(e_out));
        chk({tag, "_out_hi"}, 32'(bus.out_hi), 32'(e_hi));
        chk({tag, "_flags_czn_v"}, 32'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}),
            32'(e_czvn));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("out_valid_after_take", 32'(bus.out_valid), 0);
        chk("in_ready_back_idle", 32'(bus.in_ready), 1);
    endtask

    initial begin
        reset         = 1'b0;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.opcode    = '0;
        bus.in_sel    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_hi", 32'(bus.out_hi), 0);
        chk("rst_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b1;
        #1 chk("in_ready_after_rst", 32'(bus.in_ready), 1);

        // flags argument order: {c, z, n, v}
        issue(4'd0, 8'd11, 8'd2, 1'b0);    wait_valid(lat);
        expect_res("add", lat, 2, 8'd13, 8'h00, 4'b0000);  consume();

        issue(4'd1, 8'd2, 8'd11, 1'b0);    wait_valid(lat);
        expect_res("sub", lat, 2, 8'hF7, 8'h00, 4'b1010);  consume();

        issue(4'd12, 8'd5, 8'd5, 1'b0);    wait_valid(lat);
        expect_res("cmp_eq", lat, 2, 8'h00, 8'h00, 4'b0100);  consume();

        issue(4'd13, 8'd200, 8'd3, 1'b0);  wait_valid(lat);
        expect_res("mul", lat, 9, 8'h58, 8'h02, 4'b0000);  consume();

        issue(4'd13, 8'd0, 8'd3, 1'b0);    wait_valid(lat);
        expect_res("mul_zero", lat, 9, 8'h00, 8'h00, 4'b0100);  consume();

        issue(4'd6, 8'hFF, 8'h12, 1'b1);   wait_valid(lat);
        expect_res("inc_wrap", lat, 2, 8'h00, 8'h00, 4'b1100);  consume();

        issue(4'd7, 8'h55, 8'h00, 1'b0);   wait_valid(lat);
        expect_res("dec_zero", lat, 2, 8'hFF, 8'h00, 4'b1010);  consume();

        issue(4'd7, 8'h80, 8'h01, 1'b1);   wait_valid(lat);
        expect_res("dec_ovf", lat, 2, 8'h7F, 8'h00, 4'b0001);  consume();

        issue(4'd11, 8'hAA, 8'h03, 1'b0);  wait_valid(lat);
        expect_res("ror", lat, 2, 8'h81, 8'h00, 4'b1010);  consume();

        issue(4'd10, 8'h81, 8'h00, 1'b1);  wait_valid(lat);
        expect_res("rol", lat, 2, 8'h03, 8'h00, 4'b1000);  consume();

        issue(4'd4, 8'hF0, 8'h3C, 1'b0);   wait_valid(lat);
        expect_res("xor", lat, 2, 8'hCC, 8'h00, 4'b0010);  consume();

        issue(4'd14, 8'h80, 8'h00, 1'b1);  wait_valid(lat);
        expect_res("acc1", lat, 2, 8'h80, 8'h00, 4'b0010);  consume();

        issue(4'd14, 8'h80, 8'h00, 1'b1);  wait_valid(lat);
        expect_res("acc2", lat, 2, 8'h00, 8'h00, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out", 32'(bus.out), 0);
            chk("hold_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}), 32'hD);
            chk("hold_out_valid", 32'(bus.out_valid), 1);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        consume();

        issue(4'd14, 8'h00, 8'h05, 1'b0);  wait_valid(lat);
        expect_res("acc3", lat, 2, 8'h05, 8'h00, 4'b0000);  consume();

        issue(4'd15, 8'h77, 8'h77, 1'b0);  wait_valid(lat);
        expect_res("clracc", lat, 2, 8'h00, 8'h00, 4'b0100);  consume();

        // Stall three edges in the middle of a multiply.
        issue(4'd13, 8'd200, 8'd3, 1'b0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 3) enable = 1'b0;
            if (lat == 4) chk("stall_in_ready", 32'(bus.in_ready), 0);
            if (lat == 6) enable = 1'b1;
        end
        expect_res("mul_stall", lat, 12, 8'h58, 8'h02, 4'b0000);  consume();

        // Reset during the fourth multiply cycle aborts the operation.
        issue(4'd13, 8'd200, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out", 32'(bus.out), 0);
        chk("abort_out_hi", 32'(bus.out_hi), 0);
        chk("abort_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b1;
        #1 chk("abort_idle", 32'(bus.in_ready), 1);
        seen_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 seen_valid = seen_valid | bus.out_valid;
        end
        chk("abort_no_result", 32'(seen_valid), 0);

        issue(4'd0, 8'd1, 8'd1, 1'b0);     wait_valid(lat);
        expect_res("add_after_rst", lat, 2, 8'h02, 8'h00, 4'b0000);  consume();

        issue(4'd14, 8'd1, 8'd9, 1'b1);    wait_valid(lat);
        expect_res("acc_after_rst", lat, 2, 8'h01, 8'h00, 4'b0000);  consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
